// File: rtl/unidade_controle_pkg.sv
// -----------------------------------------------------------------------------
// pacote_controle
// Shared definitions for the multicycle control unit: FSM state type, opcode
// values, ALU operation codes and write-address mux encodings.
// -----------------------------------------------------------------------------
package pacote_controle;

   typedef enum logic [2:0] {
      BUSCA,
      DECODIFICA,
      EXECUTA,
      MEMORIA,
      ESCRITA,
      PARADO
   } estado_t;

   // Instruction opcodes
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b100;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_LI    = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   // ALU operation codes
   localparam logic [2:0] ULA_ADD   = 3'b000;
   localparam logic [2:0] ULA_SUB   = 3'b001;
   localparam logic [2:0] ULA_AND   = 3'b010;
   localparam logic [2:0] ULA_PASSB = 3'b111;

   // Write-address mux encodings
   localparam logic [1:0] SELW_RD  = 2'b00;
   localparam logic [1:0] SELW_RS1 = 2'b01;
   localparam logic [1:0] SELW_R0  = 2'b10;

endpackage

// File: rtl/unidade_controle_contador.sv
// -----------------------------------------------------------------------------
// contador_instrucoes
// Saturating up-counter with increment enable; holds at all-ones.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high clear
//   inc      : add one on this edge (ignored when saturated)
//   contagem : current count
// -----------------------------------------------------------------------------
module contador_instrucoes #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] contagem
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         contagem <= '0;
      else if (inc && (contagem != '1))
         contagem <= contagem + 1'b1;
   end

endmodule

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
// Multicycle control unit for the 8-bit, 8-register datapath. Sequences
// fetch / decode / execute / memory / write-back and drives the datapath mux
// selects and write strobes. All outputs are Moore (state + latched opcode).
//
// Optional feature macro: UNIDADE_CONTROLE_CONTADOR_EN
//   defined   -> parameter CONT_W and port Instrucoes (retired-instruction
//                counter, saturating) are present
//   undefined -> no counter, no Instrucoes port
//
// Ports:
//   Clock, Reset (async, active-high)
//   Opcode[2:0]  : IR opcode, sampled in DECODIFICA
//   Zero         : ALU zero flag (qualified in the datapath through SelCond)
//   MemPronta    : memory ready, completes a MEMORIA access
//   CarregaIR, IncrementaPC, CarregaPC, EscreveReg, LeMem, EscreveMem : strobes
//   SelRegB, SelRegW[1:0], SelDado, SelCond : datapath mux selects
//   OpULA[2:0]   : ALU operation
//   Parado       : halted
//   Instrucoes   : retired-instruction count (macro only)
// -----------------------------------------------------------------------------
module unidade_controle
   import pacote_controle::*;
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
#(
   parameter int unsigned CONT_W = 16
)
`endif
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [2:0] Opcode,
   input  logic       Zero,
   input  logic       MemPronta,
   output logic       CarregaIR,
   output logic       IncrementaPC,
   output logic       CarregaPC,
   output logic       SelRegB,
   output logic [1:0] SelRegW,
   output logic       SelDado,
   output logic       SelCond,
   output logic       EscreveReg,
   output logic       LeMem,
   output logic       EscreveMem,
   output logic [2:0] OpULA,
   output logic       Parado
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
   ,
   output logic [CONT_W-1:0] Instrucoes
`endif
);

   estado_t    estado, prox;
   logic [2:0] op_reg;
   // Low from Reset until the first edge after release: keeps every output at
   // zero during and right after reset, so the first BUSCA cycle starts on the
   // first rising edge after Reset deasserts.
   logic       ativo;

   // Zero is applied by the datapath's PC-condition mux (SelCond); the control
   // unit itself never needs its value.
   logic       zero_unused;
   assign zero_unused = Zero;

   // State register and opcode latch
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         estado <= BUSCA;
         op_reg <= '0;
         ativo  <= 1'b0;
      end else begin
         ativo <= 1'b1;
         if (ativo) begin
            estado <= prox;
            if (estado == DECODIFICA)
               op_reg <= Opcode;
         end
      end
   end

   // Next-state logic
   always_comb begin
      prox = estado;
      case (estado)
         BUSCA:      prox = DECODIFICA;
         DECODIFICA: prox = (Opcode == OP_HALT) ? PARADO : EXECUTA;
         EXECUTA: begin
            case (op_reg)
               OP_BEQ:             prox = BUSCA;
               OP_LOAD, OP_STORE:  prox = MEMORIA;
               default:            prox = ESCRITA;
            endcase
         end
         MEMORIA: begin
            if (MemPronta)
               prox = (op_reg == OP_STORE) ? BUSCA : ESCRITA;
         end
         ESCRITA:    prox = BUSCA;
         PARADO:     prox = PARADO;
         default:    prox = BUSCA;
      endcase
   end

   // Output logic
   always_comb begin
      CarregaIR    = 1'b0;
      IncrementaPC = 1'b0;
      CarregaPC    = 1'b0;
      SelRegB      = 1'b0;
      SelRegW      = SELW_RD;
      SelDado      = 1'b0;
      SelCond      = 1'b0;
      EscreveReg   = 1'b0;
      LeMem        = 1'b0;
      EscreveMem   = 1'b0;
      OpULA        = ULA_ADD;
      Parado       = 1'b0;
      if (ativo) begin
         case (estado)
            BUSCA: begin
               LeMem        = 1'b1;
               CarregaIR    = 1'b1;
               IncrementaPC = 1'b1;
            end
            EXECUTA: begin
               case (op_reg)
                  OP_ADD, OP_SUB, OP_AND: OpULA = op_reg;
                  OP_LOAD, OP_LI:         OpULA = ULA_ADD;
                  OP_STORE: begin
                     OpULA   = ULA_ADD;
                     SelRegB = 1'b1;
                  end
                  OP_BEQ: begin
                     OpULA     = ULA_SUB;
                     SelCond   = 1'b1;
                     CarregaPC = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEMORIA: begin
               LeMem      = (op_reg == OP_LOAD);
               EscreveMem = (op_reg == OP_STORE);
            end
            ESCRITA: begin
               EscreveReg = 1'b1;
               case (op_reg)
                  OP_LOAD: begin
                     SelRegW = SELW_RS1;
                     SelDado = 1'b1;
                  end
                  OP_LI: begin
                     SelRegW = SELW_R0;
                     OpULA   = ULA_PASSB;
                  end
                  default: SelRegW = SELW_RD;
               endcase
            end
            PARADO:  Parado = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef UNIDADE_CONTROLE_CONTADOR_EN
   // One pulse on the edge that retires an instruction
   logic fim;
   assign fim = ativo &&
                ((estado == ESCRITA) ||
                 (estado == MEMORIA && op_reg == OP_STORE && MemPronta) ||
                 (estado == EXECUTA && op_reg == OP_BEQ) ||
                 (estado == DECODIFICA && Opcode == OP_HALT));

   contador_instrucoes #(
      .W (CONT_W)
   ) u_contador (
      .clk      (Clock),
      .rst      (Reset),
      .inc      (fim),
      .contagem (Instrucoes)
   );
`endif

endmodule

// File: tb/tb_unidade_controle.sv
`timescale 1ns/1ps
module tb_unidade_controle;
   import pacote_controle::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] opcode;
   logic       zero;
   logic       mem_pronta;
   logic       carrega_ir, incrementa_pc, carrega_pc, sel_reg_b;
   logic [1:0] sel_reg_w;
   logic       sel_dado, sel_cond, escreve_reg, le_mem, escreve_mem;
   logic [2:0] op_ula;
   logic       parado;
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
   localparam int unsigned CW = 3;
   logic [CW-1:0] instrucoes;
`endif

   always #5 clock = ~clock;

`ifdef UNIDADE_CONTROLE_CONTADOR_EN
   unidade_controle #(.CONT_W(CW)) dut (
`else
   unidade_controle dut (
`endif
      .Clock        (clock),
      .Reset        (reset),
      .Opcode       (opcode),
      .Zero         (zero),
      .MemPronta    (mem_pronta),
      .CarregaIR    (carrega_ir),
      .IncrementaPC (incrementa_pc),
      .CarregaPC    (carrega_pc),
      .SelRegB      (sel_reg_b),
      .SelRegW      (sel_reg_w),
      .SelDado      (sel_dado),
      .SelCond      (sel_cond),
      .EscreveReg   (escreve_reg),
      .LeMem        (le_mem),
      .EscreveMem   (escreve_mem),
      .OpULA        (op_ula),
      .Parado       (parado)
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
      ,
      .Instrucoes   (instrucoes)
`endif
   );

   // Packed view of every output: bit 14 ir ... bit 0 parado
   logic [14:0] obs;
   assign obs = {carrega_ir, incrementa_pc, carrega_pc, sel_reg_b, sel_reg_w,
                 sel_dado, sel_cond, escreve_reg, le_mem, escreve_mem, op_ula, parado};

   localparam logic [14:0] M_ALL   = '1;
   localparam logic [14:0] M_NO_OP = 15'h7FF1;            // OpULA not checked
   localparam logic [14:0] M_MEM   = 15'h77F1;            // OpULA, SelRegB not checked

   typedef struct {
      string       tag;
      logic [14:0] exp;
      logic [14:0] mask;
      logic [2:0]  opc;
      logic        z;
      logic        mp;
   } item_t;

   item_t       sb[$];
   int unsigned n_chk   = 0;
   int unsigned n_err   = 0;
   int unsigned n_instr = 0;

   function automatic logic [14:0] mkv(input logic ir, input logic ipc, input logic cpc,
                                       input logic srb, input logic [1:0] srw,
                                       input logic sd, input logic sc, input logic er,
                                       input logic lm, input logic em,
                                       input logic [2:0] op, input logic par);
      return {ir, ipc, cpc, srb, srw, sd, sc, er, lm, em, op, par};
   endfunction

   task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input string tag, input logic [14:0] exp, input logic [14:0] mask,
                       input logic [2:0] opc, input logic z, input logic mp);
      item_t it;
      it.tag = tag; it.exp = exp; it.mask = mask; it.opc = opc; it.z = z; it.mp = mp;
      sb.push_back(it);
   endtask

   // Each entry: drive that cycle's inputs, compare outputs, advance one clock.
   // At most 'limit' entries are consumed; leftovers are discarded.
   task automatic drain(input int unsigned limit);
      item_t       it;
      int unsigned k = 0;
      while (sb.size() > 0 && k < limit) begin
         it         = sb.pop_front();
         opcode     = it.opc;
         zero       = it.z;
         mem_pronta = it.mp;
         chk(it.tag, obs & it.mask, it.exp & it.mask);
         @(posedge clock);
         #1;
         k++;
      end
      sb.delete();
   endtask

   task automatic chk_count();
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
      int unsigned e;
      e = (n_instr > 7) ? 7 : n_instr;
      chk("instrucoes", 15'(instrucoes), 15'(e));
`endif
   endtask

   // Queue the full expected cycle sequence of one instruction, then run it.
   task automatic instr(input logic [2:0] op, input logic z, input int unsigned nwait,
                        input int unsigned limit);
      logic [14:0] ex;
      int unsigned total;
      push("busca", mkv(1,1,0,0,2'b00,0,0,0,1,0,3'b000,0), M_ALL, 3'($urandom), 1'($urandom), 1'($urandom));
      push("decodifica", '0, M_ALL, op, 1'($urandom), 1'($urandom));
      if (op == OP_HALT) begin
         for (int i = 0; i < 20; i++)
            push("parado", mkv(0,0,0,0,2'b00,0,0,0,0,0,3'b000,1), M_ALL, 3'($urandom), 1'($urandom), 1'($urandom));
      end else begin
         case (op)
            OP_ADD, OP_SUB, OP_AND: ex = mkv(0,0,0,0,2'b00,0,0,0,0,0,op,0);
            OP_STORE:               ex = mkv(0,0,0,1,2'b00,0,0,0,0,0,3'b000,0);
            OP_BEQ:                 ex = mkv(0,0,1,0,2'b00,0,1,0,0,0,3'b001,0);
            default:                ex = '0;
         endcase
         push("executa", ex, M_ALL, 3'($urandom), z, 1'($urandom));
         if (op == OP_LOAD || op == OP_STORE) begin
            for (int unsigned j = 0; j <= nwait; j++)
               push("memoria", mkv(0,0,0,0,2'b00,0,0,0,op == OP_LOAD,op == OP_STORE,3'b000,0),
                    M_MEM, 3'($urandom), 1'($urandom), j == nwait);
         end
         if (op == OP_LOAD)
            push("escrita_load", mkv(0,0,0,0,2'b01,1,0,1,0,0,3'b000,0), M_NO_OP, 3'($urandom), 1'($urandom), 1'($urandom));
         else if (op == OP_LI)
            push("escrita_li", mkv(0,0,0,0,2'b10,0,0,1,0,0,3'b111,0), M_ALL, 3'($urandom), 1'($urandom), 1'($urandom));
         else if (op != OP_BEQ && op != OP_STORE)
            push("escrita_ula", mkv(0,0,0,0,2'b00,0,0,1,0,0,3'b000,0), M_NO_OP, 3'($urandom), 1'($urandom), 1'($urandom));
      end
      total = sb.size();
      drain(limit);
      if (limit >= total) begin
         n_instr++;
         chk_count();
      end
   endtask

   initial begin
      reset      = 1'b1;
      opcode     = 3'b000;
      zero       = 1'b0;
      mem_pronta = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset", obs, '0);
      chk_count();
      reset = 1'b0;
      chk("pre_busca", obs, '0);
      @(posedge clock);
      #1;

      instr(OP_ADD,   1'b0, 0, 1000);
      instr(OP_LOAD,  1'b0, 2, 1000);
      instr(OP_BEQ,   1'b1, 0, 1000);
      instr(OP_STORE, 1'b0, 0, 1000);
      instr(OP_LI,    1'b0, 0, 1000);
      instr(OP_SUB,   1'b0, 0, 1000);
      instr(OP_AND,   1'b0, 0, 1000);
      instr(OP_LOAD,  1'b0, 0, 1000);
      instr(OP_STORE, 1'b0, 1, 1000);
      instr(OP_BEQ,   1'b0, 0, 1000);

      // STORE stalled in MEMORIA, then reset mid-access
      instr(OP_STORE, 1'b0, 5, 5);
      chk("memoria_antes_reset", 15'(escreve_mem), 15'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("reset_assincrono", obs, '0);
      n_instr = 0;
      chk_count();
      @(posedge clock);
      #1;
      chk("reset_mantido", obs, '0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      instr(OP_ADD,  1'b0, 0, 1000);
      instr(OP_HALT, 1'b0, 0, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
